// File: rtl/mem_pkg.sv
// Shared op codes, FSM encoding, latched-operand payload and op->byte-count decode for the MEM stage.
package mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned NB_W   = 3;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LH   = 3'd2,
        LD_LW   = 3'd3,
        LD_LBU  = 3'd4,
        LD_LHU  = 3'd5
    } ld_op_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } st_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_LTAIL  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // Operand fields held for the duration of one memory op
    typedef struct packed {
        logic              is_store;
        logic [2:0]        ld_op;
        logic [REG_W-1:0]  wd;
        logic              wreg;
        logic [CNT_W-1:0]  last;
    } op_ctl_t;

    // Bytes moved by an op; a store wins over a load, 0 means no memory op
    function automatic logic [NB_W-1:0] op_bytes(input logic [2:0] rd, input logic [1:0] wr);
        logic [NB_W-1:0] n;
        n = '0;
        if (wr != ST_NONE) begin
            case (wr)
                ST_SB:   n = NB_W'(1);
                ST_SH:   n = NB_W'(2);
                default: n = NB_W'(4);
            endcase
        end else begin
            case (rd)
                LD_LB, LD_LBU: n = NB_W'(1);
                LD_LH, LD_LHU: n = NB_W'(2);
                LD_LW:         n = NB_W'(4);
                default:       n = '0;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/load_ext.sv
// Sign/zero extension of an assembled little-endian load word according to the load op.
module load_ext
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] i_word,
    input  logic [2:0]        i_op,
    output logic [DATA_W-1:0] o_data_c
);

    // Select width and extension from the op
    always_comb begin
        o_data_c = '0;
        case (i_op)
            LD_LB:   o_data_c = {{24{i_word[7]}}, i_word[7:0]};
            LD_LH:   o_data_c = {{16{i_word[15]}}, i_word[15:0]};
            LD_LW:   o_data_c = i_word;
            LD_LBU:  o_data_c = {24'd0, i_word[7:0]};
            LD_LHU:  o_data_c = {16'd0, i_word[15:0]};
            default: o_data_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: byte-serial loads/stores over a synchronous byte RAM, pass-through for non-memory ops.
module mem_access
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        mem_read,
    input  logic [1:0]        mem_write,
    input  logic [REG_W-1:0]  mem_wd,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic [REG_W-1:0]  wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              stall_req
);

    state_e             r_state,    w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
    op_ctl_t            r_ctl,      w_ctl_nxt;
    logic [ADDR_W-1:0]  r_addr,     w_addr_nxt;
    logic [DATA_W-1:0]  r_wdata,    w_wdata_nxt;
    logic [DATA_W-1:0]  r_ldata,    w_ldata_nxt;
    logic [ADDR_W-1:0]  r_ram_a,    w_ram_a_nxt;
    logic               r_ram_wr,   w_ram_wr_nxt;
    logic [7:0]         r_ram_dout, w_ram_dout_nxt;

    logic [NB_W-1:0]    w_nbytes;
    logic               w_op_seen;
    logic               w_new_store;
    logic [CNT_W-1:0]   w_next_idx;
    logic [CNT_W-1:0]   w_prev_idx;
    logic [ADDR_W-1:0]  w_next_addr;
    logic [DATA_W-1:0]  w_ext;

    assign w_nbytes    = op_bytes(mem_read, mem_write);
    assign w_op_seen   = (w_nbytes != '0);
    assign w_new_store = (mem_write != ST_NONE);
    assign w_next_idx  = r_cnt + CNT_W'(1);
    assign w_prev_idx  = r_cnt - CNT_W'(1);
    assign w_next_addr = r_addr + ADDR_W'(w_next_idx);

    assign ram_a    = r_ram_a;
    assign ram_wr   = r_ram_wr;
    assign ram_dout = r_ram_dout;

    load_ext u_load_ext (
        .i_word   (r_ldata),
        .i_op     (r_ctl.ld_op),
        .o_data_c (w_ext)
    );

    // Next-state, datapath updates and combinational MEM/WB outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ctl_nxt      = r_ctl;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_ldata_nxt    = r_ldata;
        w_ram_a_nxt    = r_ram_a;
        w_ram_wr_nxt   = r_ram_wr;
        w_ram_dout_nxt = r_ram_dout;
        wb_wd          = mem_wd;
        wb_wreg        = mem_wreg;
        wb_wdata       = mem_wdata;
        stall_req      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_op_seen) begin
                    stall_req          = 1'b1;
                    wb_wreg            = 1'b0;
                    w_ctl_nxt.is_store = w_new_store;
                    w_ctl_nxt.ld_op    = mem_read;
                    w_ctl_nxt.wd       = mem_wd;
                    w_ctl_nxt.wreg     = mem_wreg;
                    w_ctl_nxt.last     = CNT_W'(w_nbytes - NB_W'(1));
                    w_addr_nxt         = mem_waddr;
                    w_wdata_nxt        = mem_wdata;
                    w_ldata_nxt        = '0;
                    w_cnt_nxt          = '0;
                    w_ram_a_nxt        = mem_waddr;
                    w_ram_wr_nxt       = w_new_store;
                    if (w_new_store) begin
                        w_ram_dout_nxt = mem_wdata[7:0];
                    end
                    w_state_nxt        = S_ACCESS;
                end
            end
            S_ACCESS: begin
                stall_req = 1'b1;
                wb_wd     = '0;
                wb_wreg   = 1'b0;
                wb_wdata  = '0;
                // RAM data lags its address by one cycle, so byte cnt-1 arrives now
                if (!r_ctl.is_store && (r_cnt != '0)) begin
                    w_ldata_nxt[{w_prev_idx, 3'b000} +: 8] = ram_din;
                end
                if (r_cnt == r_ctl.last) begin
                    w_ram_a_nxt  = '0;
                    w_ram_wr_nxt = 1'b0;
                    w_state_nxt  = r_ctl.is_store ? S_DONE : S_LTAIL;
                end else begin
                    w_cnt_nxt   = w_next_idx;
                    w_ram_a_nxt = w_next_addr;
                    if (r_ctl.is_store) begin
                        w_ram_dout_nxt = r_wdata[{w_next_idx, 3'b000} +: 8];
                    end
                end
            end
            S_LTAIL: begin
                stall_req = 1'b1;
                wb_wd     = '0;
                wb_wreg   = 1'b0;
                wb_wdata  = '0;
                w_ldata_nxt[{r_ctl.last, 3'b000} +: 8] = ram_din;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                wb_wd       = r_ctl.wd;
                wb_wreg     = r_ctl.wreg & ~r_ctl.is_store;
                wb_wdata    = r_ctl.is_store ? '0 : w_ext;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Byte counter, operand latches, assembly register and RAM drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_ctl      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ldata    <= '0;
            r_ram_a    <= '0;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= '0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_ctl      <= w_ctl_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_ldata    <= w_ldata_nxt;
            r_ram_a    <= w_ram_a_nxt;
            r_ram_wr   <= w_ram_wr_nxt;
            r_ram_dout <= w_ram_dout_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a transaction-level model of the MEM stage.
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stall_req;

    mem_access #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .ram_a     (ram_a),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device RAM (written by the DUT) and reference RAM (written by the model)
    logic [7:0] dev_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] bg(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] dev_rd(input logic [31:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return bg(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return bg(a);
    endfunction

    // Synchronous byte RAM: read data one cycle after the address
    always @(posedge clk) begin
        ram_din = dev_rd(ram_a);
        if (ram_wr) dev_mem[ram_a] = ram_dout;
    end

    // Expected outputs for the current cycle
    logic        chk_en, e_stall, e_wreg, chk_wb, e_ram_wr, chk_dout, chk_lit;
    logic [4:0]  e_wd;
    logic [31:0] e_wdata, e_ram_a, e_lit;
    logic [7:0]  e_dout;
    int          n_vec, n_err;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("stall_req", 32'(stall_req), 32'(e_stall));
            cmp("wb_wreg", 32'(wb_wreg), 32'(e_wreg));
            if (chk_wb) begin
                cmp("wb_wd", 32'(wb_wd), 32'(e_wd));
                cmp("wb_wdata", wb_wdata, e_wdata);
            end
            cmp("ram_wr", 32'(ram_wr), 32'(e_ram_wr));
            cmp("ram_a", ram_a, e_ram_a);
            if (chk_dout) cmp("ram_dout", 32'(ram_dout), 32'(e_dout));
            if (chk_lit) cmp("wb_wdata_literal", wb_wdata, e_lit);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] rd, input logic [1:0] wr, input logic [4:0] wd,
                          input logic wreg, input logic [31:0] addr, input logic [31:0] wdata);
        mem_read = rd; mem_write = wr; mem_wd = wd;
        mem_wreg = wreg; mem_waddr = addr; mem_wdata = wdata;
    endtask

    task automatic garble();
        set_in(3'($urandom), 2'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom);
    endtask

    task automatic exp_busy(input logic wr, input logic [31:0] a, input logic cd, input logic [7:0] d);
        e_stall = 1'b1; e_wreg = 1'b0; chk_wb = 1'b1; e_wd = '0; e_wdata = '0;
        e_ram_wr = wr; e_ram_a = a; chk_dout = cd; e_dout = d;
    endtask

    // Present one instruction and follow it to completion
    task automatic issue(input logic [2:0] rd, input logic [1:0] wr, input logic [4:0] wd,
                         input logic wreg, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit use_lit, input logic [31:0] lit);
        int          n;
        bit          st;
        logic [31:0] res;
        st = (wr != 2'd0);
        if (st) n = (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : 4;
        else begin
            case (rd)
                3'd1, 3'd4: n = 1;
                3'd2, 3'd5: n = 2;
                3'd3:       n = 4;
                default:    n = 0;
            endcase
        end
        set_in(rd, wr, wd, wreg, addr, wdata);
        e_ram_wr = 1'b0; e_ram_a = '0; chk_dout = 1'b0;
        e_lit = lit;
        if (n == 0) begin
            e_stall = 1'b0; e_wreg = wreg; chk_wb = 1'b1; e_wd = wd; e_wdata = wdata;
            chk_lit = use_lit;
            step();
            chk_lit = 1'b0;
        end else begin
            e_stall = 1'b1; e_wreg = 1'b0; chk_wb = 1'b0; chk_lit = 1'b0;
            step();
            for (int k = 0; k < n; k++) begin
                garble();
                exp_busy(st, addr + 32'(k), st, wdata[8*k +: 8]);
                if (st) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
                step();
            end
            if (!st) begin
                garble();
                exp_busy(1'b0, 32'd0, 1'b0, 8'd0);
                step();
            end
            garble();
            e_stall = 1'b0; chk_wb = 1'b1; e_wd = wd; e_ram_wr = 1'b0; e_ram_a = '0; chk_dout = 1'b0;
            if (st) begin
                e_wreg = 1'b0; e_wdata = '0;
            end else begin
                res = '0;
                for (int k = 0; k < n; k++) res = res + (32'(ref_rd(addr + 32'(k))) << (8 * k));
                if (rd == 3'd1 && res >= 32'd128)   res = res - 32'd256;
                if (rd == 3'd2 && res >= 32'd32768) res = res - 32'd65536;
                e_wreg = wreg; e_wdata = res;
            end
            chk_lit = use_lit;
            step();
            chk_lit = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  wr;
        n_vec = 0; n_err = 0;
        chk_en = 1'b0; chk_lit = 1'b0; chk_dout = 1'b0; chk_wb = 1'b0;
        e_lit = '0; e_dout = '0;
        rst = 1'b1;
        set_in(3'd0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        step(); step();
        // Reset state: idle pass-through, RAM port cleared
        e_stall = 1'b0; e_wreg = 1'b0; chk_wb = 1'b1; e_wd = '0; e_wdata = '0;
        e_ram_wr = 1'b0; e_ram_a = '0; chk_dout = 1'b1; e_dout = 8'd0;
        chk_en = 1'b1;
        step();
        chk_dout = 1'b0;
        rst = 1'b0;

        // ALU pass-through
        issue(3'd0, 2'd0, 5'd5, 1'b1, 32'h0, 32'h1234, 1'b1, 32'h1234);
        // SW then LW back
        issue(3'd0, 2'd3, 5'd1, 1'b1, 32'h100, 32'hA1B2C3D4, 1'b0, 0);
        issue(3'd3, 2'd0, 5'd2, 1'b1, 32'h100, 32'h0, 1'b1, 32'hA1B2C3D4);
        // Byte / half extension
        issue(3'd0, 2'd1, 5'd3, 1'b0, 32'h180, 32'h12345680, 1'b0, 0);
        issue(3'd1, 2'd0, 5'd4, 1'b1, 32'h180, 32'h0, 1'b1, 32'hFFFFFF80);
        issue(3'd4, 2'd0, 5'd4, 1'b1, 32'h180, 32'h0, 1'b1, 32'h00000080);
        issue(3'd0, 2'd2, 5'd6, 1'b1, 32'h190, 32'h0000F001, 1'b0, 0);
        issue(3'd2, 2'd0, 5'd7, 1'b1, 32'h190, 32'h0, 1'b1, 32'hFFFFF001);
        issue(3'd5, 2'd0, 5'd7, 1'b1, 32'h190, 32'h0, 1'b1, 32'h0000F001);
        // Misaligned and wrapping words
        issue(3'd0, 2'd3, 5'd8, 1'b1, 32'h3, 32'h11223344, 1'b0, 0);
        issue(3'd3, 2'd0, 5'd9, 1'b1, 32'h3, 32'h0, 1'b1, 32'h11223344);
        issue(3'd0, 2'd3, 5'd10, 1'b1, 32'hFFFFFFFE, 32'hCAFEBABE, 1'b0, 0);
        issue(3'd3, 2'd0, 5'd11, 1'b1, 32'hFFFFFFFE, 32'h0, 1'b1, 32'hCAFEBABE);
        issue(3'd4, 2'd0, 5'd11, 1'b1, 32'h0, 32'h0, 1'b1, 32'h000000FE);

        // Reset during the cnt=1 access of a store
        set_in(3'd0, 2'd3, 5'd12, 1'b1, 32'h300, 32'hDEADBEEF);
        e_stall = 1'b1; e_wreg = 1'b0; chk_wb = 1'b0; e_ram_wr = 1'b0; e_ram_a = '0; chk_dout = 1'b0;
        step();
        garble();
        exp_busy(1'b1, 32'h300, 1'b1, 8'hEF);
        ref_mem[32'h300] = 8'hEF;
        step();
        garble();
        rst = 1'b1;
        exp_busy(1'b1, 32'h301, 1'b1, 8'hBE);
        ref_mem[32'h301] = 8'hBE;
        step();
        rst = 1'b0;
        set_in(3'd0, 2'd0, 5'd7, 1'b0, 32'h300, 32'h55);
        e_stall = 1'b0; e_wreg = 1'b0; chk_wb = 1'b1; e_wd = 5'd7; e_wdata = 32'h55;
        e_ram_wr = 1'b0; e_ram_a = '0; chk_dout = 1'b0;
        step();

        // Back-to-back SB then LW; read+write together acts as SB; reads 6/7 are no-ops
        issue(3'd0, 2'd1, 5'd13, 1'b1, 32'h1A0, 32'h00000077, 1'b0, 0);
        issue(3'd3, 2'd0, 5'd14, 1'b1, 32'h1A0, 32'h0, 1'b1, 32'hF8F9FA77);
        issue(3'd3, 2'd1, 5'd15, 1'b1, 32'h1B0, 32'h000000C3, 1'b0, 0);
        issue(3'd4, 2'd0, 5'd16, 1'b1, 32'h1B0, 32'h0, 1'b1, 32'h000000C3);
        issue(3'd6, 2'd0, 5'd17, 1'b1, 32'h1B0, 32'hABCD, 1'b1, 32'hABCD);
        issue(3'd7, 2'd0, 5'd18, 1'b0, 32'h1B0, 32'h5678, 1'b0, 0);

        // Random mix over a small address window and the wrap region
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = 32'h400 + 32'($urandom_range(0, 15));
                2:       a = 32'hFFFFFFF8 + 32'($urandom_range(0, 15));
                default: a = $urandom;
            endcase
            wr = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
            issue(3'($urandom), wr, 5'($urandom), 1'($urandom), a, $urandom, 1'b0, 0);
        end

        chk_en = 1'b0;
        set_in(3'd0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        step(); step();
        foreach (ref_mem[k]) cmp("ram_contents", 32'(dev_rd(k)), 32'(ref_mem[k]));
        foreach (dev_mem[k]) cmp("ram_unexpected_write", 32'(ref_mem.exists(k)), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
